// File: rtl/cic_decim_ctrl.sv
// CIC decimator control: warm-up flush, decimated-sample capture into a small FIFO, MSB-first byte serializer.
// Define CIC_CTRL_OVERFLOW_EN to enable the sticky overflow flag (otherwise overflow is tied low).
module cic_decim_ctrl #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        ratio,
  input  logic [7:0]        num_samples,
  input  logic [DATA_W-1:0] filt_z,
  output logic              filt_clr,
  output logic              dec_strobe,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              overflow
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [7:0]        m_r, nsamp_r, phase, phase_nxt, samp_cnt, samp_inc;
  logic              warm_seen, cap_en;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       fifo_cnt;
  logic [15:0]       word16;
  logic [7:0]        lo_byte;
  logic              lo_pend;
  logic              capture, fifo_full, fifo_empty, push, pop, slot_free, ser_idle, count_done;

  assign capture    = cap_en && (state == S_RUN);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);
  assign slot_free  = !byte_valid || byte_ready;
  assign pop        = (state != S_IDLE) && slot_free && !lo_pend && !fifo_empty;
  // a full FIFO still accepts a push when a word leaves in the same cycle
  assign push       = capture && (!fifo_full || pop);
  assign ser_idle   = !byte_valid && !lo_pend;
  assign samp_inc   = samp_cnt + 8'd1;
  assign count_done = capture && (nsamp_r != 8'd0) && (samp_inc == nsamp_r);
  assign phase_nxt  = (phase == m_r - 8'd1) ? 8'd0 : phase + 8'd1;
  assign word16     = 16'(mem[rd_ptr]);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FLUSH;
      S_FLUSH: if (stop) state_nxt = S_DRAIN;
               else if (dec_strobe && warm_seen) state_nxt = S_RUN;
      S_RUN:   if (stop || count_done) state_nxt = S_DRAIN;
      S_DRAIN: if (fifo_empty && ser_idle) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      m_r        <= 8'd2;
      nsamp_r    <= '0;
      phase      <= '0;
      samp_cnt   <= '0;
      warm_seen  <= 1'b0;
      cap_en     <= 1'b0;
      filt_clr   <= 1'b0;
      dec_strobe <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != S_IDLE);
      filt_clr <= (state == S_IDLE) && start;
      // only strobes issued in RUN produce captures; warm-up strobes are discarded
      cap_en   <= dec_strobe && (state == S_RUN);
      if (state == S_IDLE) begin
        if (start) begin
          m_r       <= (ratio < 8'd2) ? 8'd2 : ratio;
          nsamp_r   <= num_samples;
          phase     <= '0;
          samp_cnt  <= '0;
          warm_seen <= 1'b0;
        end
        dec_strobe <= 1'b0;
      end else if (state_nxt == S_FLUSH || state_nxt == S_RUN) begin
        phase      <= phase_nxt;
        dec_strobe <= (phase_nxt == m_r - 8'd1);
      end else begin
        dec_strobe <= 1'b0;
      end
      if (state == S_FLUSH && dec_strobe) warm_seen <= 1'b1;
      if (capture) samp_cnt <= samp_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= filt_z;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_ONE;
      else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_ONE;
    end
  end

  // byte_out holds the current byte, lo_byte the second half of the word in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_out   <= '0;
      byte_valid <= 1'b0;
      lo_byte    <= '0;
      lo_pend    <= 1'b0;
    end else if (state != S_IDLE && slot_free) begin
      if (lo_pend) begin
        byte_out   <= lo_byte;
        byte_valid <= 1'b1;
        lo_pend    <= 1'b0;
      end else if (!fifo_empty) begin
        byte_out   <= word16[15:8];
        lo_byte    <= word16[7:0];
        lo_pend    <= 1'b1;
        byte_valid <= 1'b1;
      end else begin
        byte_valid <= 1'b0;
      end
    end
  end

`ifdef CIC_CTRL_OVERFLOW_EN
  logic drop;
  assign drop = capture && fifo_full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          overflow <= 1'b0;
    else if (state == S_IDLE && start)  overflow <= 1'b0;
    else if (drop)                      overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Bench for cic_decim_ctrl: vector table of whole acquisitions, directed corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_cic_decim_ctrl;
  localparam int DEPTH = 4;
`ifdef CIC_CTRL_OVERFLOW_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, stop, byte_ready;
  logic [7:0]  ratio, num_samples;
  logic [15:0] filt_z;
  logic        filt_clr, dec_strobe, byte_valid, busy, overflow;
  logic [7:0]  byte_out;

  always #5 clk = ~clk;

  cic_decim_ctrl #(.DATA_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .ratio(ratio),
    .num_samples(num_samples), .filt_z(filt_z), .filt_clr(filt_clr),
    .dec_strobe(dec_strobe), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .busy(busy), .overflow(overflow)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] ratio;
    logic [7:0] ns;
    int         m;
    int         busy_len;
    int         nbytes;
    int         restart;
  } vec_t;
  vec_t vecs[5];

  // reference model state: 0 idle, 1 flush, 2 run, 3 drain; m_t counts cycles since flush entry
  int          m_st, m_t, m_M, m_N, m_cnt;
  logic        m_ovf;
  logic [15:0] q_fifo[$];
  logic [7:0]  q_ser[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] zval(input int t);
    logic [7:0] b;
    b = t[7:0];
    return {b, b ^ 8'h5A};
  endfunction

  task automatic model_reset();
    m_st = 0; m_t = 0; m_M = 2; m_N = 0; m_cnt = 0; m_ovf = 1'b0;
    q_fifo.delete();
    q_ser.delete();
  endtask

  // advance the model across one rising edge using the inputs currently driven
  task automatic model_edge();
    logic        cap, pop, done;
    logic [15:0] w;
    cap  = (m_st == 2) && (m_t % m_M == 0) && (m_t >= 3 * m_M);
    pop  = (m_st != 0) && (q_fifo.size() > 0) &&
           (q_ser.size() == 0 || (q_ser.size() == 1 && byte_ready));
    done = (q_fifo.size() == 0) && (q_ser.size() == 0);
    if (m_st != 0 && q_ser.size() > 0 && byte_ready) void'(q_ser.pop_front());
    if (pop) begin
      w = q_fifo.pop_front();
      q_ser.push_back(w[15:8]);
      q_ser.push_back(w[7:0]);
    end
    if (cap) begin
      if (q_fifo.size() < DEPTH) q_fifo.push_back(filt_z);
      else if (OVF_ON) m_ovf = 1'b1;
    end
    case (m_st)
      0: if (start) begin
           m_st = 1; m_t = 0; m_M = (ratio < 2) ? 2 : int'(ratio);
           m_N = int'(num_samples); m_cnt = 0; m_ovf = 1'b0;
         end
      1: begin
           if (stop) m_st = 3;
           else if (m_t == 2 * m_M - 1) m_st = 2;
           m_t++;
         end
      2: begin
           if (stop || (cap && m_N != 0 && m_cnt + 1 == m_N)) m_st = 3;
           if (cap) m_cnt++;
           m_t++;
         end
      default: if (done) m_st = 0;
    endcase
  endtask

  task automatic acq(input vec_t v);
    int          t, s1, s2, nby, bcyc, clr_bad, j;
    logic [15:0] w;
    ratio = v.ratio; num_samples = v.ns; byte_ready = 1'b1; stop = 1'b0;
    filt_z = '0; start = 1'b1;
    cyc();
    start = 1'b0;
    t = 0; s1 = -1; s2 = -1; nby = 0; bcyc = 0; clr_bad = 0;
    chk("acq_clr_first", filt_clr, 1);
    while (busy && t < 500) begin
      bcyc++;
      if (filt_clr && t != 0) clr_bad++;
      if (dec_strobe) begin
        if (s1 < 0) s1 = t;
        else if (s2 < 0) s2 = t;
      end
      if (byte_valid) begin
        j = nby / 2 + 1;
        w = zval((j + 2) * v.m);
        chk("acq_byte", byte_out, (nby % 2 == 0) ? w[15:8] : w[7:0]);
        nby++;
      end
      start = (t == v.restart);
      if (t == v.restart) begin
        ratio = 8'd2; num_samples = 8'd0;
      end
      filt_z = zval(t);
      cyc();
      t++;
    end
    start = 1'b0;
    chk("acq_busy_len", bcyc, v.busy_len);
    chk("acq_first_strobe", s1, v.m - 1);
    chk("acq_period", s2 - s1, v.m);
    chk("acq_nbytes", nby, v.nbytes);
    chk("acq_clr_once", clr_bad, 0);
    chk("acq_no_ovf", overflow, 0);
  endtask

  initial begin
    int          nby, qbad;
    logic [15:0] w;

    vecs[0] = '{8'd4, 8'd3, 4, 25, 6, -1};
    vecs[1] = '{8'd0, 8'd1, 2, 11, 2, -1};
    vecs[2] = '{8'd1, 8'd2, 2, 13, 4, -1};
    vecs[3] = '{8'd7, 8'd2, 7, 33, 4, -1};
    vecs[4] = '{8'd4, 8'd2, 4, 21, 4, 5};

    reset = 1'b1; start = 1'b0; stop = 1'b0; ratio = '0; num_samples = '0;
    filt_z = '0; byte_ready = 1'b0;
    cyc(); cyc();
    chk("reset_state", {filt_clr, dec_strobe, byte_valid, busy, overflow, byte_out}, 0);
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 5; i++) acq(vecs[i]);

    // stop during warm-up goes straight to drain, then idle
    ratio = 8'd4; num_samples = 8'd3; byte_ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_flush_drain", {busy, dec_strobe, byte_valid}, 3'b100);
    cyc();
    chk("stop_flush_idle", {busy, byte_valid}, 0);

    // consumer stalled in continuous mode: FIFO fills, bytes hold steady
    ratio = 8'd2; num_samples = 8'd0; byte_ready = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    qbad = 0;
    for (int t = 0; t < 40; t++) begin
      if (t >= 8 && (!byte_valid || byte_out != 8'd6)) qbad++;
      filt_z = zval(t);
      cyc();
    end
    chk("stall_stable", qbad, 0);
    chk("stall_overflow", overflow, OVF_ON);
    stop = 1'b1; filt_z = zval(40);
    cyc();
    stop = 1'b0; byte_ready = 1'b1; nby = 0;
    for (int c = 0; c < 100 && busy; c++) begin
      if (byte_valid) begin
        w = zval(2 * (nby / 2 + 3));
        chk("stall_drain_byte", byte_out, (nby % 2 == 0) ? w[15:8] : w[7:0]);
        nby++;
      end
      cyc();
    end
    chk("stall_drain_count", nby, 10);
    chk("stall_drain_idle", busy, 0);
    chk("stall_ovf_sticky", overflow, OVF_ON);

    // reset mid-run with two words buffered
    ratio = 8'd4; num_samples = 8'd0; byte_ready = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int t = 0; t < 18; t++) begin
      filt_z = zval(t);
      cyc();
    end
    chk("pre_reset_byte", {byte_valid, byte_out}, {1'b1, 8'd12});
    reset = 1'b1;
    #1;
    chk("reset_mid_outputs", {filt_clr, dec_strobe, byte_valid, busy, overflow, byte_out}, 0);
    cyc();
    reset = 1'b0; byte_ready = 1'b1; qbad = 0;
    for (int c = 0; c < 30; c++) begin
      if (byte_valid || busy) qbad++;
      cyc();
    end
    chk("post_reset_quiet", qbad, 0);

    // randomized traffic against the reference model
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      start       = ($urandom_range(0, 9) == 0);
      stop        = ($urandom_range(0, 59) == 0);
      ratio       = 8'($urandom_range(0, 6));
      num_samples = 8'($urandom_range(0, 5));
      filt_z      = 16'($urandom);
      byte_ready  = ($urandom_range(0, 3) != 0);
      model_edge();
      cyc();
      chk("rnd_ctrl", {busy, dec_strobe, filt_clr, byte_valid, overflow},
          {m_st != 0,
           (m_st == 1 || m_st == 2) && (m_t % m_M == m_M - 1),
           m_st == 1 && m_t == 0,
           q_ser.size() > 0,
           m_ovf});
      if (q_ser.size() > 0) chk("rnd_byte", byte_out, q_ser[0]);
    end
    start = 1'b0; stop = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cic_decim_ctrl.md
CIC_DECIM_CTRL -- requirements
Module: cic_decim_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, sets the width of the decimated sample from the CIC filter.
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two), sets the sample buffer depth in words.
REQ-003 Port clk  input  1  clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  one-cycle request to begin an acquisition; ignored while busy=1.
REQ-006 Port stop  input  1  request to end an acquisition early; ignored in IDLE.
REQ-007 Port ratio  input  8  decimation factor M, sampled on accepted start.
REQ-008 Port num_samples  input  8  samples to deliver, sampled on accepted start; 0 means continuous.
REQ-009 Port filt_z  input  DATA_W  decimated output Z of the CIC datapath.
REQ-010 Port filt_clr  output  1  synchronous clear pulse to the CIC datapath.
REQ-011 Port dec_strobe  output  1  comb-stage enable, high one cycle in every M.
REQ-012 Port byte_out  output  8  serialized sample byte.
REQ-013 Port byte_valid  output  1  byte_out holds a valid byte.
REQ-014 Port byte_ready  input  1  consumer accepts byte_out when high together with byte_valid.
REQ-015 Port busy  output  1  high in any state other than IDLE.
REQ-016 Port overflow  output  1  sticky flag: a sample was dropped because the FIFO was full.

Function
REQ-017 FSM states SHALL be IDLE, FLUSH, RUN and DRAIN; every output is registered.
REQ-018 IDLE->FLUSH on start: latch M=max(ratio,2) and num_samples; pulse filt_clr for exactly the first FLUSH cycle; clear the phase counter, sample counter and overflow.
REQ-019 The phase counter counts 0..M-1 and wraps in FLUSH and RUN; dec_strobe=1 exactly when the counter equals M-1; it is held at 0 in IDLE and DRAIN.
REQ-020 FLUSH discards the first two dec_strobe events (comb warm-up) and enters RUN on the cycle after the second.
REQ-021 In RUN, filt_z is captured on the cycle after each dec_strobe (cap_en = dec_strobe delayed by one cycle) and pushed into the FIFO.
REQ-022 A push into a full FIFO with no simultaneous pop is dropped and sets overflow; a push and pop in the same cycle on a full FIFO both succeed.
REQ-023 The sample counter counts accepted and dropped captures; RUN->DRAIN on the capture that makes the count equal num_samples (num_samples!=0), or on stop.
REQ-024 stop in FLUSH moves directly to DRAIN; start while busy has no effect.
REQ-025 DRAIN->IDLE on the cycle after the FIFO is empty and the serializer holds no word.
REQ-026 The serializer pops one word and emits byte_out=word[15:8], then word[7:0]; each byte advances only on byte_valid&byte_ready.
REQ-027 byte_out and byte_valid SHALL stay stable while byte_valid=1 and byte_ready=0; back-to-back bytes sustain one byte per cycle with byte_ready held high.
REQ-028 The serializer keeps running in all non-IDLE states, independent of dec_strobe.

Reset
REQ-029 reset forces IDLE: all counters, FIFO pointers and the serializer cleared; filt_clr, dec_strobe, byte_valid, busy and overflow are 0; byte_out is 0x00.
REQ-030 reset asserted mid-acquisition discards buffered samples with no further byte_valid until a new start.

Configuration
REQ-031 With macro CIC_CTRL_OVERFLOW_EN defined, overflow behaves per REQ-016/REQ-022; when the macro is undefined, overflow is tied to 0 and dropped samples are silent, with all other behaviour identical.

Verification
REQ-032 ratio=4, num_samples=3, byte_ready=1 -> filt_clr pulse, strobes every 4 cycles, two discarded, 6 bytes MSB-first, busy falls after the last byte.
REQ-033 ratio=0 -> dec_strobe period 2 cycles (M clamped to 2).
REQ-034 ratio=2, num_samples=0, byte_ready=0 for 40 cycles -> FIFO fills with 4 words, overflow=1 (macro on) or overflow=0 (macro off); bytes stable while stalled.
REQ-035 stop asserted during FLUSH -> DRAIN then IDLE in 2 cycles, no byte_valid.
REQ-036 reset asserted mid-RUN with 2 words buffered -> all outputs 0 immediately; no bytes appear afterwards.
REQ-037 start pulsed while busy=1 -> ignored; latched ratio and num_samples unchanged.
